mm_operand_stage: RTL and testbench

MMX operand-fetch stage directly upstream of `alu64`. Holds the eight 64-bit MM architectural registers, a one-bit-per-register pending-write scoreboard, and a writeback bypass. Accepts decoded MMX micro-ops through a valid/ready handshake and presents registered `MM_A`, `MM_B`, `imm` and `operation_select` to the ALU. Consumes ALU results returning on the writeback port.

---
 rtl/mm_operand_stage.sv | 138 +++++++++++++
 tb/tb_mm_operand_stage.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/mm_operand_stage.sv
// MMX operand-fetch stage: eight-entry MM register file, pending-write scoreboard,
// writeback bypass and a registered valid/ready operand latch feeding alu64.
module mm_operand_stage #(
    parameter int  NUM_MM_REGS = 8,
    parameter int  DATA_WIDTH  = 64,
    localparam int IDX_W       = $clog2(NUM_MM_REGS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [IDX_W-1:0]      in_src_a,
    input  logic [IDX_W-1:0]      in_src_b,
    input  logic [IDX_W-1:0]      in_dest,
    input  logic                  in_wr_en,
    input  logic [2:0]            in_op,
    input  logic [31:0]           in_imm,
    input  logic                  wb_valid,
    input  logic [IDX_W-1:0]      wb_dest,
    input  logic [DATA_WIDTH-1:0] wb_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] MM_A,
    output logic [DATA_WIDTH-1:0] MM_B,
    output logic [31:0]           imm,
    output logic [2:0]            operation_select,
    output logic [IDX_W-1:0]      out_dest,
    output logic                  out_wr_en
);

    logic [DATA_WIDTH-1:0] r_regs [NUM_MM_REGS];
    logic [NUM_MM_REGS-1:0] r_pending;

    logic                  r_out_valid;
    logic [DATA_WIDTH-1:0] r_mm_a;
    logic [DATA_WIDTH-1:0] r_mm_b;
    logic [31:0]           r_imm;
    logic [2:0]            r_op;
    logic [IDX_W-1:0]      r_dest;
    logic                  r_wr_en;

    logic                  w_use_a;
    logic                  w_use_b;
    logic                  w_wr_en;
    logic                  w_byp_a;
    logic                  w_byp_b;
    logic                  w_byp_dest;
    logic                  w_raw;
    logic                  w_waw;
    logic                  w_hazard;
    logic                  w_issue;
    logic [DATA_WIDTH-1:0] w_opnd_a;
    logic [DATA_WIDTH-1:0] w_opnd_b;

    // Ops 6 and 7 are illegal: they read nothing and never claim a destination.
    always_comb begin
        w_use_a = 1'b0;
        w_use_b = 1'b0;
        w_wr_en = in_wr_en;
        case (in_op)
            3'd0, 3'd1, 3'd2: begin
                w_use_a = 1'b1;
                w_use_b = 1'b1;
            end
            3'd3, 3'd5: w_use_b = 1'b1;
            3'd4:       w_use_a = 1'b1;
            default:    w_wr_en = 1'b0;
        endcase
    end

    assign w_byp_a    = wb_valid && (wb_dest == in_src_a);
    assign w_byp_b    = wb_valid && (wb_dest == in_src_b);
    assign w_byp_dest = wb_valid && (wb_dest == in_dest);

    assign w_opnd_a = w_byp_a ? wb_data : r_regs[in_src_a];
    assign w_opnd_b = w_byp_b ? wb_data : r_regs[in_src_b];

    // A pending source that is being written back this cycle is satisfied by the bypass.
    assign w_raw    = (w_use_a && r_pending[in_src_a] && !w_byp_a)
                   || (w_use_b && r_pending[in_src_b] && !w_byp_b);
    assign w_waw    = w_wr_en && r_pending[in_dest] && !w_byp_dest;
    assign w_hazard = w_raw || w_waw;

    assign in_ready = (!r_out_valid || out_ready) && !w_hazard;
    assign w_issue  = in_valid && in_ready;

    // Set-before-clear ordering lets a new claim win over a same-cycle writeback.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_MM_REGS; i++) begin
                r_regs[i] <= '0;
            end
            r_pending <= '0;
        end else begin
            for (int i = 0; i < NUM_MM_REGS; i++) begin
                if (w_issue && w_wr_en && (in_dest == IDX_W'(i))) begin
                    r_pending[i] <= 1'b1;
                end else if (wb_valid && (wb_dest == IDX_W'(i))) begin
                    r_pending[i] <= 1'b0;
                end
                if (wb_valid && (wb_dest == IDX_W'(i))) begin
                    r_regs[i] <= wb_data;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_mm_a      <= '0;
            r_mm_b      <= '0;
            r_imm       <= '0;
            r_op        <= '0;
            r_dest      <= '0;
            r_wr_en     <= 1'b0;
        end else if (w_issue) begin
            r_out_valid <= 1'b1;
            r_mm_a      <= w_opnd_a;
            r_mm_b      <= w_opnd_b;
            r_imm       <= in_imm;
            r_op        <= in_op;
            r_dest      <= in_dest;
            r_wr_en     <= w_wr_en;
        end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid        = r_out_valid;
    assign MM_A             = r_mm_a;
    assign MM_B             = r_mm_b;
    assign imm              = r_imm;
    assign operation_select = r_op;
    assign out_dest         = r_dest;
    assign out_wr_en        = r_wr_en;

endmodule

// File: tb/tb_mm_operand_stage.sv
// Bench for mm_operand_stage: directed vector table, reset sequences and a randomized
// run, all checked against an abstract register/scoreboard model.
module tb_mm_operand_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_src_a, in_src_b, in_dest;
    logic        in_wr_en;
    logic [2:0]  in_op;
    logic [31:0] in_imm;
    logic        wb_valid;
    logic [2:0]  wb_dest;
    logic [63:0] wb_data;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] MM_A, MM_B;
    logic [31:0] imm;
    logic [2:0]  operation_select;
    logic [2:0]  out_dest;
    logic        out_wr_en;

    always #5 clk = ~clk;

    mm_operand_stage dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_src_a(in_src_a), .in_src_b(in_src_b), .in_dest(in_dest),
        .in_wr_en(in_wr_en), .in_op(in_op), .in_imm(in_imm),
        .wb_valid(wb_valid), .wb_dest(wb_dest), .wb_data(wb_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .MM_A(MM_A), .MM_B(MM_B), .imm(imm), .operation_select(operation_select),
        .out_dest(out_dest), .out_wr_en(out_wr_en)
    );

    typedef struct {
        bit          directed;
        bit          iv;
        logic [2:0]  op, sa, sb, dst;
        bit          wr;
        logic [31:0] im;
        bit          wbv;
        logic [2:0]  wbd;
        logic [63:0] wbdata;
        bit          ordy;
        bit          exp_rdy;
        bit          exp_ov;
        bit          chk_ab;
        logic [63:0] exp_a, exp_b;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state: architectural registers, pending flags and the operand latch.
    logic [63:0] m_regs [8];
    bit          m_pend [8];
    bit          m_ov;
    logic [63:0] m_a, m_b;
    logic [31:0] m_imm;
    logic [2:0]  m_op, m_dest;
    bit          m_wr;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic void m_reset();
        for (int i = 0; i < 8; i++) begin
            m_regs[i] = '0;
            m_pend[i] = 0;
        end
        m_ov = 0; m_a = '0; m_b = '0; m_imm = '0; m_op = '0; m_dest = '0; m_wr = 0;
    endfunction

    function automatic bit reads_a(input logic [2:0] op);
        return op inside {3'd0, 3'd1, 3'd2, 3'd4};
    endfunction

    function automatic bit reads_b(input logic [2:0] op);
        return op inside {3'd0, 3'd1, 3'd2, 3'd3, 3'd5};
    endfunction

    function automatic vec_t mk(bit iv, int op, int sa, int sb, int dst, bit wr, logic [31:0] im,
                                bit wbv, int wbd, logic [63:0] wbdata, bit ordy,
                                bit er, bit eov, bit chk, logic [63:0] ea, logic [63:0] eb);
        vec_t v;
        v.directed = 1; v.iv = iv; v.op = 3'(op); v.sa = 3'(sa); v.sb = 3'(sb); v.dst = 3'(dst);
        v.wr = wr; v.im = im; v.wbv = wbv; v.wbd = 3'(wbd); v.wbdata = wbdata; v.ordy = ordy;
        v.exp_rdy = er; v.exp_ov = eov; v.chk_ab = chk; v.exp_a = ea; v.exp_b = eb;
        return v;
    endfunction

    task automatic check_outputs(input string tag);
        check({tag, ".out_valid"}, 64'(out_valid), 64'(m_ov));
        check({tag, ".MM_A"}, MM_A, m_a);
        check({tag, ".MM_B"}, MM_B, m_b);
        check({tag, ".imm"}, 64'(imm), 64'(m_imm));
        check({tag, ".op/dest/wr"}, 64'({operation_select, out_dest, out_wr_en}),
              64'({m_op, m_dest, m_wr}));
    endtask

    // One cycle: drive after a falling edge, check ready, clock, check the latch.
    task automatic step(input vec_t v, input string tag);
        bit byp_a, byp_b, byp_d, wr_eff, raw, waw, rdy, issue;
        in_valid = v.iv; in_op = v.op; in_src_a = v.sa; in_src_b = v.sb; in_dest = v.dst;
        in_wr_en = v.wr; in_imm = v.im; wb_valid = v.wbv; wb_dest = v.wbd;
        wb_data = v.wbdata; out_ready = v.ordy;
        #1;
        byp_a  = v.wbv && (v.wbd == v.sa);
        byp_b  = v.wbv && (v.wbd == v.sb);
        byp_d  = v.wbv && (v.wbd == v.dst);
        wr_eff = v.wr && (v.op < 3'd6);
        raw    = (reads_a(v.op) && m_pend[v.sa] && !byp_a) || (reads_b(v.op) && m_pend[v.sb] && !byp_b);
        waw    = wr_eff && m_pend[v.dst] && !byp_d;
        rdy    = (!m_ov || v.ordy) && !raw && !waw;
        issue  = v.iv && rdy;
        check({tag, ".in_ready"}, 64'(in_ready), 64'(rdy));
        if (v.directed) check({tag, ".tbl_ready"}, 64'(in_ready), 64'(v.exp_rdy));
        @(posedge clk);
        if (issue) begin
            m_a  = byp_a ? v.wbdata : m_regs[v.sa];
            m_b  = byp_b ? v.wbdata : m_regs[v.sb];
            m_imm = v.im; m_op = v.op; m_dest = v.dst; m_wr = wr_eff; m_ov = 1;
        end else if (m_ov && v.ordy) begin
            m_ov = 0;
        end
        if (v.wbv) begin
            m_regs[v.wbd] = v.wbdata;
            m_pend[v.wbd] = 0;
        end
        if (issue && wr_eff) m_pend[v.dst] = 1;
        @(negedge clk);
        check_outputs(tag);
        if (v.directed) begin
            check({tag, ".tbl_out_valid"}, 64'(out_valid), 64'(v.exp_ov));
            if (v.chk_ab) begin
                check({tag, ".tbl_MM_A"}, MM_A, v.exp_a);
                check({tag, ".tbl_MM_B"}, MM_B, v.exp_b);
            end
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, ".out_valid"}, 64'(out_valid), 64'd0);
        check({tag, ".MM_A"}, MM_A, 64'd0);
        check({tag, ".MM_B"}, MM_B, 64'd0);
        check({tag, ".fields"}, 64'({imm, operation_select, out_dest, out_wr_en}), 64'd0);
    endtask

    localparam logic [63:0] V1   = 64'h0001_0002_0003_0004;
    localparam logic [63:0] VDB  = 64'hDEAD_BEEF_0000_0001;
    localparam logic [63:0] V2   = 64'h0000_0000_0000_1111;

    vec_t tbl [15];
    vec_t rv;

    initial begin
        tbl[0]  = mk(0, 0, 0, 0, 0, 0, 32'h0,  1, 1, V1,  1, 1, 0, 0, '0,  '0);
        tbl[1]  = mk(1, 0, 1, 1, 2, 1, 32'h5,  0, 0, '0,  1, 1, 1, 1, V1,  V1);
        tbl[2]  = mk(1, 1, 0, 0, 3, 1, 32'h0,  0, 0, '0,  1, 1, 1, 1, '0,  '0);
        tbl[3]  = mk(1, 0, 3, 0, 5, 1, 32'h0,  0, 0, '0,  1, 0, 0, 0, '0,  '0);
        tbl[4]  = mk(1, 0, 3, 0, 5, 1, 32'h0,  0, 0, '0,  1, 0, 0, 0, '0,  '0);
        tbl[5]  = mk(1, 0, 3, 0, 5, 1, 32'h0,  1, 3, VDB, 1, 1, 1, 1, VDB, '0);
        tbl[6]  = mk(1, 3, 5, 0, 6, 1, 32'h1B, 0, 0, '0,  1, 1, 1, 0, '0,  '0);
        tbl[7]  = mk(1, 4, 0, 0, 2, 1, 32'h0,  0, 0, '0,  1, 0, 0, 0, '0,  '0);
        tbl[8]  = mk(1, 4, 0, 0, 2, 1, 32'h0,  1, 2, V2,  1, 1, 1, 1, '0,  '0);
        tbl[9]  = mk(1, 6, 5, 5, 5, 1, 32'h7,  0, 0, '0,  1, 1, 1, 0, '0,  '0);
        tbl[10] = mk(1, 0, 1, 1, 1, 0, 32'h9,  0, 0, '0,  0, 0, 1, 0, '0,  '0);
        tbl[11] = mk(1, 0, 1, 1, 1, 0, 32'h9,  0, 0, '0,  0, 0, 1, 0, '0,  '0);
        tbl[12] = mk(1, 0, 1, 1, 1, 0, 32'h9,  0, 0, '0,  0, 0, 1, 0, '0,  '0);
        tbl[13] = mk(1, 0, 1, 1, 1, 0, 32'h9,  0, 0, '0,  0, 0, 1, 0, '0,  '0);
        tbl[14] = mk(1, 0, 1, 1, 1, 0, 32'h9,  0, 0, '0,  1, 1, 1, 1, V1,  V1);

        rst_n = 1'b0; in_valid = 0; in_op = 0; in_src_a = 0; in_src_b = 0; in_dest = 0;
        in_wr_en = 0; in_imm = 0; wb_valid = 0; wb_dest = 0; wb_data = 0; out_ready = 1;
        m_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_reset_state("reset");
        check("reset.in_ready", 64'(in_ready), 64'd1);

        for (int i = 0; i < 15; i++) step(tbl[i], $sformatf("vec%0d", i));

        // Reset in the middle of traffic: latch valid and reg4 pending.
        step(mk(1, 1, 0, 0, 4, 1, 32'h3, 0, 0, '0, 1, 1, 1, 0, '0, '0), "pre_rst");
        rst_n = 1'b0;
        #1;
        check_reset_state("mid_reset");
        m_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step(mk(1, 0, 4, 4, 0, 0, 32'h0, 0, 0, '0, 1, 1, 1, 1, '0, '0), "post_rst");

        for (int i = 0; i < 400; i++) begin
            rv.directed = 0;
            rv.iv     = ($urandom_range(0, 3) != 0);
            rv.op     = 3'($urandom_range(0, 7));
            rv.sa     = 3'($urandom_range(0, 7));
            rv.sb     = 3'($urandom_range(0, 7));
            rv.dst    = 3'($urandom_range(0, 7));
            rv.wr     = ($urandom_range(0, 3) != 0);
            rv.im     = $urandom;
            rv.wbv    = ($urandom_range(0, 2) == 0);
            rv.wbd    = 3'($urandom_range(0, 7));
            rv.wbdata = {$urandom, $urandom};
            rv.ordy   = ($urandom_range(0, 3) != 0);
            rv.exp_rdy = 0; rv.exp_ov = 0; rv.chk_ab = 0; rv.exp_a = '0; rv.exp_b = '0;
            step(rv, $sformatf("rnd%0d", i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
